// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// One request in flight at most; the response is a one-cycle valid strobe.
interface if_stage_if;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem reads and
// feeds IF/ID, honouring stalls, downstream redirects and HLT.
//
// state | meaning
// FETCH | request issued for pc this cycle
// WAIT  | request outstanding, waiting for imem_valid
// HOLD  | instruction parked in hold_instr while stalled
// DROP  | redirected with a response still outstanding; discard it
// HALT  | HLT delivered; fetch stopped until a redirect
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    if_stage_if.master      imem,
    input  logic            stall,
    input  logic            redirect,
    input  logic [15:0]     redirect_pc,
    output logic [15:0]     pc_plus2,
    output logic [15:0]     if_instr,
    output logic            if_inval,
    output logic            ifid_wen,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_instr_q, hold_instr_d;

    logic        avail;
    logic [15:0] src_instr;
    logic        req_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_instr_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Source of the instruction that could be delivered this cycle.
    always_comb begin
        avail     = 1'b0;
        src_instr = 16'h0000;
        case (state_q)
            S_WAIT: begin
                avail     = imem.imem_valid;
                src_instr = imem.imem_rdata;
            end
            S_HOLD: begin
                avail     = 1'b1;
                src_instr = hold_instr_q;
            end
            default: begin
                avail     = 1'b0;
                src_instr = 16'h0000;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        req_int      = 1'b0;
        if_instr     = 16'h0000;
        if_inval     = 1'b1;

        case (state_q)
            S_FETCH: begin
                req_int = 1'b1;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_HOLD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    // Only a WAIT without its response still has one in flight.
                    if (state_q == S_WAIT && !imem.imem_valid)
                        state_d = S_DROP;
                    else
                        state_d = S_FETCH;
                end else if (avail) begin
                    if (!stall) begin
                        if_instr = src_instr;
                        if_inval = 1'b0;
                        if (src_instr[15:12] == HLT_OPCODE) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + 16'd2;
                            state_d = S_FETCH;
                        end
                    end else if (state_q == S_WAIT) begin
                        hold_instr_d = imem.imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (redirect)
                    pc_d = redirect_pc;
                // A redirect here must not strand us waiting for a second response.
                if (imem.imem_valid)
                    state_d = S_FETCH;
            end
            S_HALT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            req_int  = 1'b0;
            if_inval = 1'b1;
            if_instr = 16'h0000;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_int;
    assign pc_plus2       = pc_q + 16'd2;
    assign ifid_wen       = rst | redirect | ~stall;
    assign halted         = ~rst & (state_q == S_HALT);

endmodule
